// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load unit.
package dmem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Captured request: only the byte offset and the load kind matter after issue.
  typedef struct packed {
    logic [1:0] off;
    logic [5:0] op;
  } ld_req_t;

  // A load is legal when the opcode is known and its natural alignment holds.
  function automatic logic load_legal(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU: load_legal = 1'b1;
      OP_LH, OP_LHU: load_legal = ~off[0];
      OP_LW:         load_legal = (off == 2'b00);
      default:       load_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Big-endian lane select plus sign/zero extension; purely combinational.
module load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [5:0]  opcode,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Byte 0 sits in the most significant lane, halfword 0 in the upper half.
  always_comb begin
    case (offset)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = offset[1] ? word[15:0] : word[31:16];
  end

  // Extend according to the load kind; unknown kinds yield zero.
  always_comb begin
    case (opcode)
      OP_LB:   data = {{24{b[7]}}, b};
      OP_LBU:  data = {24'd0, b};
      OP_LH:   data = {{16{h[15]}}, h};
      OP_LHU:  data = {16'd0, h};
      OP_LW:   data = word;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_load_unit.sv
// Single-outstanding load unit: issues one word read, extracts and extends
// the addressed lane, and holds the result until the consumer takes it.
module dmem_load_unit
  import dmem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [5:0]  req_opcode,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam logic [2:0] RL = 3'(READ_LATENCY);

  state_t      state, state_nx;
  ld_req_t     req_q;
  logic [2:0]  cnt;
  logic [31:0] ext;
  logic        legal;
  logic        acc;

  assign legal = load_legal(req_opcode, req_addr[1:0]);
  // Accept is derived from state directly to keep it off the comb FSM loop.
  assign acc   = req_valid && (state == IDLE);

  load_extract u_ext (
    .word   (mem_rd),
    .offset (req_q.off),
    .opcode (req_q.op),
    .data   (ext)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs; illegal requests skip the memory.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = legal ? WAIT : RESP;
      end
      WAIT: if (cnt == 3'd0) state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture request, strobe memory once, count down the read
  // latency (reloaded per request), then register the extracted result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q     <= '0;
      cnt       <= 3'd0;
      mem_re    <= 1'b0;
      mem_addr  <= 32'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end else begin
      mem_re <= acc && legal;
      if (acc) begin
        req_q    <= '{off: req_addr[1:0], op: req_opcode};
        cnt      <= RL;
        if (legal) begin
          mem_addr <= {req_addr[31:2], 2'b00};
        end else begin
          resp_data <= 32'd0;
          resp_err  <= 1'b1;
        end
      end else if (state == WAIT) begin
        if (cnt == 3'd0) begin
          resp_data <= ext;
          resp_err  <= 1'b0;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_load_unit.sv
// Directed bench for dmem_load_unit with READ_LATENCY=1.
module tb_dmem_load_unit;

  localparam int RL = 1;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [5:0]  req_opcode;
  logic        mem_re;
  logic [31:0] mem_addr, mem_rd;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int vec  = 0;
  int errs = 0;

  dmem_load_unit #(.READ_LATENCY(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_opcode (req_opcode),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string nm);
    vec++; if (mem_re !== 1'b0)       begin errs++; $display("FAIL %s mem_re got %b want 0", nm, mem_re); end
    vec++; if (mem_addr !== 32'd0)    begin errs++; $display("FAIL %s mem_addr got %h want 0", nm, mem_addr); end
    vec++; if (resp_valid !== 1'b0)   begin errs++; $display("FAIL %s resp_valid got %b want 0", nm, resp_valid); end
    vec++; if (resp_data !== 32'd0)   begin errs++; $display("FAIL %s resp_data got %h want 0", nm, resp_data); end
    vec++; if (resp_err !== 1'b0)     begin errs++; $display("FAIL %s resp_err got %b want 0", nm, resp_err); end
    vec++; if (req_ready !== 1'b1)    begin errs++; $display("FAIL %s req_ready got %b want 1", nm, req_ready); end
  endtask

  // Full legal load starting in the current cycle (k); checks every cycle.
  task automatic do_load(input string nm, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    logic [31:0] wa;
    wa = {addr[31:2], 2'b00};
    req_valid = 1'b1; req_opcode = op; req_addr = addr; resp_ready = 1'b1;
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL %s accept req_ready got %b want 1", nm, req_ready); end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= RL; i++) begin
      mem_rd = (i == RL) ? rdata : ~rdata;
      vec++; if (mem_re !== (i == 0)) begin errs++; $display("FAIL %s wait%0d mem_re got %b want %b", nm, i, mem_re, (i == 0)); end
      vec++; if (mem_addr !== wa)     begin errs++; $display("FAIL %s wait%0d mem_addr got %h want %h", nm, i, mem_addr, wa); end
      vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL %s wait%0d resp_valid got %b want 0", nm, i, resp_valid); end
      vec++; if (req_ready !== 1'b0)  begin errs++; $display("FAIL %s wait%0d req_ready got %b want 0", nm, i, req_ready); end
      tick();
    end
    mem_rd = ~rdata;
    vec++; if (resp_valid !== 1'b1) begin errs++; $display("FAIL %s resp_valid got %b want 1", nm, resp_valid); end
    vec++; if (resp_data !== exp)   begin errs++; $display("FAIL %s resp_data got %h want %h", nm, resp_data, exp); end
    vec++; if (resp_err !== 1'b0)   begin errs++; $display("FAIL %s resp_err got %b want 0", nm, resp_err); end
    vec++; if (mem_re !== 1'b0)     begin errs++; $display("FAIL %s resp mem_re got %b want 0", nm, mem_re); end
    tick();
    vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL %s after resp_valid got %b want 0", nm, resp_valid); end
    vec++; if (req_ready !== 1'b1)  begin errs++; $display("FAIL %s after req_ready got %b want 1", nm, req_ready); end
  endtask

  // Illegal request: response next cycle, no memory access.
  task automatic do_err(input string nm, input logic [5:0] op, input logic [31:0] addr);
    req_valid = 1'b1; req_opcode = op; req_addr = addr; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    vec++; if (resp_valid !== 1'b1)  begin errs++; $display("FAIL %s resp_valid got %b want 1", nm, resp_valid); end
    vec++; if (resp_err !== 1'b1)    begin errs++; $display("FAIL %s resp_err got %b want 1", nm, resp_err); end
    vec++; if (resp_data !== 32'd0)  begin errs++; $display("FAIL %s resp_data got %h want 0", nm, resp_data); end
    vec++; if (mem_re !== 1'b0)      begin errs++; $display("FAIL %s mem_re got %b want 0", nm, mem_re); end
    vec++; if (req_ready !== 1'b0)   begin errs++; $display("FAIL %s req_ready got %b want 0", nm, req_ready); end
    tick();
    vec++; if (resp_valid !== 1'b0)  begin errs++; $display("FAIL %s after resp_valid got %b want 0", nm, resp_valid); end
    vec++; if (mem_re !== 1'b0)      begin errs++; $display("FAIL %s after mem_re got %b want 0", nm, mem_re); end
    vec++; if (req_ready !== 1'b1)   begin errs++; $display("FAIL %s after req_ready got %b want 1", nm, req_ready); end
  endtask

  task automatic test_reset();
    check_reset_vals("reset");
    // Release mid-cycle; the very next edge must accept.
    reset = 1'b1;
    do_load("first_after_reset", LB, 32'h5, 32'h12F45678, 32'hFFFFFFF4);
  endtask

  task automatic test_extract();
    do_load("lbu_off3",   LBU, 32'h7,   32'h123456AB, 32'h000000AB);
    do_load("lh_neg",     LH,  32'h2,   32'h0000800F, 32'hFFFF800F);
    do_load("lhu_same",   LHU, 32'h2,   32'h0000800F, 32'h0000800F);
    do_load("lb_off0",    LB,  32'h100, 32'h80123456, 32'hFFFFFF80);
    do_load("lh_off0pos", LH,  32'h20,  32'h7FFF8000, 32'h00007FFF);
    do_load("lbu_off2",   LBU, 32'h12,  32'h0011FF22, 32'h000000FF);
    do_load("lw",         LW,  32'hC,   32'hDEADBEEF, 32'hDEADBEEF);
  endtask

  task automatic test_errors();
    do_err("lw_misalign",  LW,  32'h6);
    do_err("lh_odd",       LH,  32'h3);
    do_err("lhu_odd",      LHU, 32'h1);
    do_err("bad_op_a",     6'b100010, 32'h0);
    do_err("bad_op_b",     6'b000000, 32'h4);
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_opcode = LW; req_addr = 32'h10; resp_ready = 1'b0;
    tick();
    // A different request stays asserted through the stall and must be ignored.
    req_opcode = LB; req_addr = 32'h20;
    for (int i = 0; i <= RL; i++) begin
      mem_rd = (i == RL) ? 32'hCAFEF00D : 32'h0;
      tick();
    end
    mem_rd = 32'h0;
    for (int i = 0; i < 5; i++) begin
      vec++; if (resp_valid !== 1'b1)        begin errs++; $display("FAIL stall%0d resp_valid got %b want 1", i, resp_valid); end
      vec++; if (resp_data !== 32'hCAFEF00D) begin errs++; $display("FAIL stall%0d resp_data got %h want cafef00d", i, resp_data); end
      vec++; if (resp_err !== 1'b0)          begin errs++; $display("FAIL stall%0d resp_err got %b want 0", i, resp_err); end
      vec++; if (req_ready !== 1'b0)         begin errs++; $display("FAIL stall%0d req_ready got %b want 0", i, req_ready); end
      vec++; if (mem_addr !== 32'h10)        begin errs++; $display("FAIL stall%0d mem_addr got %h want 10", i, mem_addr); end
      vec++; if (mem_re !== 1'b0)            begin errs++; $display("FAIL stall%0d mem_re got %b want 0", i, mem_re); end
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    vec++; if (resp_valid !== 1'b1) begin errs++; $display("FAIL release resp_valid got %b want 1", resp_valid); end
    tick();
    do_load("after_release", LBU, 32'h13, 32'h11223344, 32'h00000044);
  endtask

  task automatic test_reset_mid();
    // Reset during WAIT.
    req_valid = 1'b1; req_opcode = LB; req_addr = 32'h5; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    vec++; if (mem_re !== 1'b1) begin errs++; $display("FAIL mid_wait mem_re got %b want 1", mem_re); end
    reset = 1'b0;
    #1;
    check_reset_vals("reset_in_wait");
    #2 reset = 1'b1;
    mem_rd = 32'h12F45678;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL dropped%0d resp_valid got %b want 0", i, resp_valid); end
      vec++; if (mem_re !== 1'b0)     begin errs++; $display("FAIL dropped%0d mem_re got %b want 0", i, mem_re); end
    end
    do_load("lw_after_reset", LW, 32'h8, 32'hA5A55A5A, 32'hA5A55A5A);
    // Reset during a stalled RESP.
    req_valid = 1'b1; req_opcode = LW; req_addr = 32'h6; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    vec++; if (resp_err !== 1'b1) begin errs++; $display("FAIL mid_resp resp_err got %b want 1", resp_err); end
    reset = 1'b0;
    #1;
    check_reset_vals("reset_in_resp");
    #2 reset = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL dropped_resp%0d resp_valid got %b want 0", i, resp_valid); end
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_opcode = 6'd0;
    mem_rd = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_extract();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
